// File: rtl/ula_fl_sched.sv
// ula_fl_sched: round-robin arbiter in front of one shared ula_fl ALU.
// Registers the winning operands, stretches DIV, returns a tagged result.
module ula_fl_sched #(
  parameter  int EXP      = 8,
  parameter  int MAN      = 23,
  parameter  int NREQ     = 4,
  parameter  int DIV_WAIT = 2,
  localparam int W        = EXP + MAN + 1,
  localparam int IW       = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [4*NREQ-1:0] req_op,
  input  logic [W*NREQ-1:0] req_in1,
  input  logic [W*NREQ-1:0] req_in2,
  output logic [3:0]        alu_op,
  output logic [W-1:0]      alu_in1,
  output logic [W-1:0]      alu_in2,
  input  logic [W-1:0]      alu_out,
  output logic              rsp_valid,
  output logic [IW-1:0]     rsp_id,
  output logic [W-1:0]      rsp_data,
  output logic              rsp_err,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WAIT
  } state_t;

  localparam logic [3:0] OP_DIV = 4'd4;

  state_t        state_q, state_d;
  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] id_q, id_d;
  logic [3:0]    op_q, op_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [W-1:0]  in1_q, in1_d;
  logic [W-1:0]  in2_q, in2_d;
  logic          vld_q, vld_d;
  logic          err_q, err_d;
  logic [IW-1:0] rid_q, rid_d;
  logic [W-1:0]  dat_q, dat_d;

  logic          gnt_any;
  logic [IW-1:0] gnt_id;

  logic [3:0]    ops  [NREQ];
  logic [W-1:0]  in1s [NREQ];
  logic [W-1:0]  in2s [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign ops[i]  = req_op[4*i +: 4];
    assign in1s[i] = req_in1[W*i +: W];
    assign in2s[i] = req_in2[W*i +: W];
  end

  // First valid requester after the last grant, wrapping at NREQ
  always_comb begin
    int k;
    k       = 0;
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      k = int'(last_q) + i;
      if (k >= NREQ) k -= NREQ;
      if (!gnt_any && req_valid[k[IW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_id  = k[IW-1:0];
      end
    end
  end

  // Next state, grant pulse and response capture
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    id_d      = id_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    in1_d     = in1_q;
    in2_d     = in2_q;
    vld_d     = 1'b0;
    err_d     = err_q;
    rid_d     = rid_q;
    dat_d     = dat_q;
    req_ready = '0;
    unique case (state_q)
      IDLE: begin
        if (gnt_any && rst) begin
          req_ready[gnt_id] = 1'b1;
          last_d = gnt_id;
          id_d   = gnt_id;
          op_d   = ops[gnt_id];
          if (ops[gnt_id][3:1] == 3'b111) begin
            vld_d = 1'b1;
            err_d = 1'b1;
            dat_d = '0;
            rid_d = gnt_id;
          end else begin
            in1_d   = in1s[gnt_id];
            in2_d   = in2s[gnt_id];
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        if (op_q == OP_DIV && DIV_WAIT > 0) begin
          cnt_d   = 4'(DIV_WAIT - 1);
          state_d = WAIT;
        end else begin
          vld_d   = 1'b1;
          err_d   = 1'b0;
          dat_d   = alu_out;
          rid_d   = id_q;
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          vld_d   = 1'b1;
          err_d   = 1'b0;
          dat_d   = alu_out;
          rid_d   = id_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any op in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= IW'(NREQ - 1);
      id_q    <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      in1_q   <= '0;
      in2_q   <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      rid_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      rid_q   <= rid_d;
      dat_q   <= dat_d;
    end
  end

  assign busy      = (state_q == EXEC) || (state_q == WAIT);
  assign alu_op    = busy ? op_q : 4'd0;
  assign alu_in1   = in1_q;
  assign alu_in2   = in2_q;
  assign rsp_valid = vld_q;
  assign rsp_err   = err_q;
  assign rsp_id    = rid_q;
  assign rsp_data  = dat_q;

endmodule

// File: tb/tb_ula_fl_sched.sv
// tb_ula_fl_sched: directed checks of grant order, latency, DIV stretch,
// invalid ops, reset abort and back-to-back accept.
module tb_ula_fl_sched;

  localparam int EXP  = 8;
  localparam int MAN  = 23;
  localparam int NREQ = 4;
  localparam int DW   = 2;
  localparam int W    = EXP + MAN + 1;
  localparam int IW   = 2;

  localparam logic [W-1:0] F1_5 = 32'h3FC0_0000;
  localparam logic [W-1:0] F2_5 = 32'h4020_0000;
  localparam logic [W-1:0] F4_0 = 32'h4080_0000;
  localparam logic [W-1:0] F6_0 = 32'h40C0_0000;
  localparam logic [W-1:0] F2_0 = 32'h4000_0000;
  localparam logic [W-1:0] F3_0 = 32'h4040_0000;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [4*NREQ-1:0] req_op;
  logic [W*NREQ-1:0] req_in1;
  logic [W*NREQ-1:0] req_in2;
  logic [3:0]        alu_op;
  logic [W-1:0]      alu_in1;
  logic [W-1:0]      alu_in2;
  logic [W-1:0]      alu_out;
  logic              rsp_valid;
  logic [IW-1:0]     rsp_id;
  logic [W-1:0]      rsp_data;
  logic              rsp_err;
  logic              busy;

  int checks;
  int passes;

  logic [W-1:0] ra [NREQ];
  logic [W-1:0] rb [NREQ];

  ula_fl_sched #(
    .EXP(EXP), .MAN(MAN), .NREQ(NREQ), .DIV_WAIT(DW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_in1(req_in1), .req_in2(req_in2),
    .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in ALU: exact float results for the directed vectors, xor otherwise
  always_comb begin
    alu_out = alu_in1 ^ alu_in2;
    if (alu_op == 4'd2 && alu_in1 == F1_5 && alu_in2 == F2_5)
      alu_out = F4_0;
    else if (alu_op == 4'd4 && alu_in1 == F6_0 && alu_in2 == F2_0)
      alu_out = F3_0;
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic v, input logic [3:0] o,
                         input logic [W-1:0] x, input logic [W-1:0] y);
    req_valid[i]       = v;
    req_op[4*i +: 4]   = o;
    req_in1[W*i +: W]  = x;
    req_in2[W*i +: W]  = y;
  endtask

  task automatic test_reset();
    repeat (2) nxt();
    smp();
    checks++;
    if ({req_ready, rsp_valid, rsp_err, busy, alu_op} !== 11'd0)
      $display("FAIL reset_ctl got %b want 0",
               {req_ready, rsp_valid, rsp_err, busy, alu_op});
    else passes++;
    checks++;
    if ({rsp_id, rsp_data, alu_in1, alu_in2} !== '0)
      $display("FAIL reset_data got id=%0d d=%h a=%h b=%h want 0",
               rsp_id, rsp_data, alu_in1, alu_in2);
    else passes++;
    nxt();
    rst = 1'b1;
  endtask

  task automatic test_single();
    nxt();
    set_req(0, 1'b1, 4'd2, F1_5, F2_5);
    smp();
    checks++;
    if (req_ready !== 4'b0001)
      $display("FAIL single_ready got %b want 0001", req_ready);
    else passes++;
    nxt();
    set_req(0, 1'b0, 4'd0, '0, '0);
    smp();
    checks++;
    if (alu_op !== 4'd2 || alu_in1 !== F1_5 || alu_in2 !== F2_5 ||
        busy !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL single_exec got op=%0d a=%h b=%h bz=%b v=%b want 2 %h %h 1 0",
               alu_op, alu_in1, alu_in2, busy, rsp_valid, F1_5, F2_5);
    else passes++;
    nxt();
    smp();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== F4_0 ||
        rsp_err !== 1'b0)
      $display("FAIL single_rsp got v=%b id=%0d d=%h e=%b want 1 0 %h 0",
               rsp_valid, rsp_id, rsp_data, rsp_err, F4_0);
    else passes++;
    nxt();
    smp();
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || alu_op !== 4'd0)
      $display("FAIL single_after got v=%b bz=%b op=%0d want 0 0 0",
               rsp_valid, busy, alu_op);
    else passes++;
  endtask

  task automatic test_round_robin();
    nxt();
    rst = 1'b0;
    nxt();
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      ra[i] = 32'h3F80_0000 + (i << 16);
      rb[i] = 32'h0000_1111 * (i + 1);
      set_req(i, 1'b1, 4'd3, ra[i], rb[i]);
    end
    smp();
    for (int n = 0; n < 5; n++) begin
      checks++;
      if (req_ready !== 4'(1 << (n % 4)))
        $display("FAIL rr_grant%0d got %b want %b",
                 n, req_ready, 4'(1 << (n % 4)));
      else passes++;
      if (n > 0) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'((n - 1) % 4) ||
            rsp_data !== (ra[(n-1)%4] ^ rb[(n-1)%4]) || rsp_err !== 1'b0)
          $display("FAIL rr_rsp%0d got v=%b id=%0d d=%h want 1 %0d %h",
                   n, rsp_valid, rsp_id, rsp_data, (n - 1) % 4,
                   ra[(n-1)%4] ^ rb[(n-1)%4]);
        else passes++;
      end
      nxt();
      if (n == 4)
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 4'd0, '0, '0);
      smp();
      checks++;
      if (req_ready !== 4'b0000 || busy !== 1'b1 || alu_op !== 4'd3)
        $display("FAIL rr_exec%0d got rdy=%b bz=%b op=%0d want 0000 1 3",
                 n, req_ready, busy, alu_op);
      else passes++;
      nxt();
      smp();
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 ||
        rsp_data !== (ra[0] ^ rb[0]) || req_ready !== 4'b0000)
      $display("FAIL rr_last got v=%b id=%0d d=%h rdy=%b want 1 0 %h 0000",
               rsp_valid, rsp_id, rsp_data, req_ready, ra[0] ^ rb[0]);
    else passes++;
  endtask

  task automatic test_div();
    nxt();
    set_req(1, 1'b1, 4'd4, F6_0, F2_0);
    smp();
    checks++;
    if (req_ready !== 4'b0010)
      $display("FAIL div_ready got %b want 0010", req_ready);
    else passes++;
    for (int k = 0; k < 3; k++) begin
      nxt();
      if (k == 0) set_req(1, 1'b0, 4'd0, '0, '0);
      smp();
      checks++;
      if (alu_op !== 4'd4 || alu_in1 !== F6_0 || alu_in2 !== F2_0 ||
          busy !== 1'b1 || rsp_valid !== 1'b0)
        $display("FAIL div_hold%0d got op=%0d a=%h b=%h bz=%b v=%b want 4 %h %h 1 0",
                 k, alu_op, alu_in1, alu_in2, busy, rsp_valid, F6_0, F2_0);
      else passes++;
    end
    nxt();
    smp();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== F3_0 ||
        rsp_err !== 1'b0 || busy !== 1'b0)
      $display("FAIL div_rsp got v=%b id=%0d d=%h e=%b bz=%b want 1 1 %h 0 0",
               rsp_valid, rsp_id, rsp_data, rsp_err, busy, F3_0);
    else passes++;
  endtask

  task automatic test_invalid();
    nxt();
    set_req(2, 1'b1, 4'd15, 32'h1234_5678, 32'h9ABC_DEF0);
    smp();
    checks++;
    if (req_ready !== 4'b0100 || alu_op !== 4'd0)
      $display("FAIL inv_ready got rdy=%b op=%0d want 0100 0",
               req_ready, alu_op);
    else passes++;
    nxt();
    set_req(2, 1'b0, 4'd0, '0, '0);
    smp();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== '0 ||
        rsp_id !== 2'd2)
      $display("FAIL inv_rsp got v=%b e=%b d=%h id=%0d want 1 1 0 2",
               rsp_valid, rsp_err, rsp_data, rsp_id);
    else passes++;
    checks++;
    if (alu_op !== 4'd0 || busy !== 1'b0 || alu_in1 !== F6_0 ||
        alu_in2 !== F2_0)
      $display("FAIL inv_alu got op=%0d bz=%b a=%h b=%h want 0 0 %h %h",
               alu_op, busy, alu_in1, alu_in2, F6_0, F2_0);
    else passes++;
    nxt();
    smp();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b1 || rsp_id !== 2'd2 ||
        alu_op !== 4'd0)
      $display("FAIL inv_after got v=%b e=%b id=%0d op=%0d want 0 1 2 0",
               rsp_valid, rsp_err, rsp_id, alu_op);
    else passes++;
  endtask

  task automatic test_reset_wait();
    nxt();
    set_req(3, 1'b1, 4'd4, F6_0, F2_0);
    set_req(1, 1'b1, 4'd3, 32'h0000_00AA, 32'h0000_0055);
    smp();
    checks++;
    if (req_ready !== 4'b1000)
      $display("FAIL rw_ready got %b want 1000", req_ready);
    else passes++;
    nxt();
    set_req(3, 1'b0, 4'd0, '0, '0);
    smp();
    nxt();
    smp();
    checks++;
    if (busy !== 1'b1 || alu_op !== 4'd4 || rsp_valid !== 1'b0)
      $display("FAIL rw_wait got bz=%b op=%0d v=%b want 1 4 0",
               busy, alu_op, rsp_valid);
    else passes++;
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_err, busy, alu_op} !== 11'd0 ||
        {rsp_id, rsp_data, alu_in1, alu_in2} !== '0)
      $display("FAIL rw_async got rdy=%b v=%b bz=%b op=%0d a=%h d=%h want 0",
               req_ready, rsp_valid, busy, alu_op, alu_in1, rsp_data);
    else passes++;
    for (int k = 0; k < 3; k++) begin
      nxt();
      smp();
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 4'b0000)
        $display("FAIL rw_held%0d got v=%b rdy=%b want 0 0000",
                 k, rsp_valid, req_ready);
      else passes++;
    end
    nxt();
    rst = 1'b1;
    set_req(0, 1'b1, 4'd2, F1_5, F2_5);
    set_req(3, 1'b1, 4'd4, F6_0, F2_0);
    smp();
    checks++;
    if (req_ready !== 4'b0001)
      $display("FAIL rw_regrant got %b want 0001", req_ready);
    else passes++;
    nxt();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 4'd0, '0, '0);
    nxt();
    smp();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== F4_0)
      $display("FAIL rw_rsp got v=%b id=%0d d=%h want 1 0 %h",
               rsp_valid, rsp_id, rsp_data, F4_0);
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a1, b1;
    a1 = 32'h4110_0000;
    b1 = 32'h0003_0C00;
    nxt();
    set_req(0, 1'b1, 4'd2, F1_5, F2_5);
    smp();
    checks++;
    if (req_ready !== 4'b0001)
      $display("FAIL b2b_ready0 got %b want 0001", req_ready);
    else passes++;
    nxt();
    set_req(0, 1'b0, 4'd0, '0, '0);
    set_req(1, 1'b1, 4'd3, a1, b1);
    smp();
    checks++;
    if (req_ready !== 4'b0000 || busy !== 1'b1)
      $display("FAIL b2b_exec got rdy=%b bz=%b want 0000 1",
               req_ready, busy);
    else passes++;
    nxt();
    smp();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== F4_0 ||
        req_ready !== 4'b0010)
      $display("FAIL b2b_overlap got v=%b id=%0d d=%h rdy=%b want 1 0 %h 0010",
               rsp_valid, rsp_id, rsp_data, req_ready, F4_0);
    else passes++;
    nxt();
    set_req(1, 1'b0, 4'd0, '0, '0);
    smp();
    checks++;
    if (busy !== 1'b1 || alu_op !== 4'd3 || alu_in1 !== a1 ||
        rsp_valid !== 1'b0)
      $display("FAIL b2b_exec1 got bz=%b op=%0d a=%h v=%b want 1 3 %h 0",
               busy, alu_op, alu_in1, rsp_valid, a1);
    else passes++;
    nxt();
    smp();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== (a1 ^ b1))
      $display("FAIL b2b_rsp1 got v=%b id=%0d d=%h want 1 1 %h",
               rsp_valid, rsp_id, rsp_data, a1 ^ b1);
    else passes++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    checks    = 0;
    passes    = 0;
    rst       = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_in1   = '0;
    req_in2   = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_div();
    test_invalid();
    test_reset_wait();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
